// File: rtl/pixie_dma_responder.sv
// -----------------------------------------------------------------------------
// pixie_dma_responder
//
// CPU-side bus-cycle sequencer that answers the Pixie display controller's
// DMA-out and interrupt requests with CDP1802-style machine-cycle timing.
// Each machine cycle lasts CYCLE_TICKS clk_enable ticks. The state code `sc`
// (00 fetch, 01 execute, 10 DMA, 11 interrupt) feeds the Pixie front end.
// In a DMA cycle the byte at R0 is read, presented on `data`, and R0 then
// advances by one.
//
// Parameters:
//   CYCLE_TICKS  clk_enable ticks per machine cycle (>= 4)
//   ADDR_W       width of R0 and mem_addr
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous reset, active low
//   clk_enable  CPU tick; sequencer advances only when high
//   dmao        DMA-out request from Pixie (level-sampled at cycle end)
//   int_pixie   interrupt request from Pixie (level-sampled at cycle end)
//   ie          CPU interrupt-enable flag
//   r0_wr       load R0 from r0_din (any clk, ignores clk_enable)
//   r0_din      new R0 value
//   sc          machine-cycle state code
//   mem_addr    memory read address (always R0)
//   mem_rd      one-clk read strobe at DMA tick 0
//   mem_rdata   memory read data, valid the clk after mem_rd
//   data        DMA byte presented to Pixie
//   int_ack     one-clk pulse at interrupt-cycle tick 0
//   r0          current DMA pointer
//   dma_count   DMA cycles since the last interrupt-cycle entry
// -----------------------------------------------------------------------------
module pixie_dma_responder #(
  parameter int unsigned CYCLE_TICKS = 8,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              dmao,
  input  logic              int_pixie,
  input  logic              ie,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_din,
  output logic [1:0]        sc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        data,
  output logic              int_ack,
  output logic [ADDR_W-1:0] r0,
  output logic [9:0]        dma_count
);

  localparam int unsigned     TW     = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(CYCLE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_DMA   = 2'b10,
    ST_INT   = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_t;
  logic [ADDR_W-1:0] r_r0;
  logic [7:0]        r_data;
  logic              r_rd_pend;
  logic [9:0]        r_dma_count;

  logic              w_eoc;
  logic              w_tick0;
  logic              w_dma_rd;
  logic              w_int_start;

  // Tick qualifiers: both require an enabled tick.
  assign w_eoc       = clk_enable && (r_t == T_LAST);
  assign w_tick0     = clk_enable && (r_t == '0);

  // Strobes are gated by reset so they never fire in a reset clk.
  assign w_dma_rd    = reset && (r_state == ST_DMA) && w_tick0;
  assign w_int_start = reset && (r_state == ST_INT) && w_tick0;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: state only moves at the end-of-cycle tick. DMA has
  // priority over interrupts; fetch ignores both requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_eoc) begin
      unique case (r_state)
        ST_FETCH: w_state_nxt = ST_EXEC;
        ST_EXEC: begin
          if (dmao) begin
            w_state_nxt = ST_DMA;
          end else if (int_pixie && ie) begin
            w_state_nxt = ST_INT;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_DMA, ST_INT: begin
          if (dmao) begin
            w_state_nxt = ST_DMA;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tick counter within the machine cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_t <= '0;
    end else if (clk_enable) begin
      if (r_t == T_LAST) begin
        r_t <= '0;
      end else begin
        r_t <= r_t + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // R0: a software load overrides the end-of-DMA-cycle increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_r0 <= '0;
    end else if (r0_wr) begin
      r_r0 <= r0_din;
    end else if ((r_state == ST_DMA) && w_eoc) begin
      r_r0 <= r_r0 + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read data capture: memory answers one clk after the strobe, so the byte
  // is latched on the following clk whether or not clk_enable is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= w_dma_rd;
      if (r_rd_pend) begin
        r_data <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DMA cycle counter, cleared on interrupt-cycle entry, wraps at 1023.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dma_count <= '0;
    end else if (w_int_start) begin
      r_dma_count <= '0;
    end else if ((r_state == ST_DMA) && w_eoc) begin
      r_dma_count <= r_dma_count + 10'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sc        = r_state;
  assign mem_addr  = r_r0;
  assign mem_rd    = w_dma_rd;
  assign data      = r_data;
  assign int_ack   = w_int_start;
  assign r0        = r_r0;
  assign dma_count = r_dma_count;

endmodule

// File: tb/tb_pixie_dma_responder.sv
// -----------------------------------------------------------------------------
// tb_pixie_dma_responder
//
// Directed bench for pixie_dma_responder with CYCLE_TICKS=8, ADDR_W=16.
// A synchronous byte memory answers mem_rd one clk later. Inputs change 1ns
// after the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_pixie_dma_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        dmao;
  logic        int_pixie;
  logic        ie;
  logic        r0_wr;
  logic [15:0] r0_din;
  logic [1:0]  sc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [7:0]  data;
  logic        int_ack;
  logic [15:0] r0;
  logic [9:0]  dma_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rd_pulses = 0;
  int unsigned ack_pulses = 0;

  logic [7:0] mem [0:65535];

  pixie_dma_responder #(
    .CYCLE_TICKS (8),
    .ADDR_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .dmao       (dmao),
    .int_pixie  (int_pixie),
    .ie         (ie),
    .r0_wr      (r0_wr),
    .r0_din     (r0_din),
    .sc         (sc),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .data       (data),
    .int_ack    (int_ack),
    .r0         (r0),
    .dma_count  (dma_count)
  );

  always #5 clk = ~clk;

  // Synchronous read memory
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];
  end

  // Strobe pulse counters, sampled mid-clk
  always @(negedge clk) begin
    if (mem_rd === 1'b1)  rd_pulses++;
    if (int_ack === 1'b1) ack_pulses++;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clocks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One enabled tick followed by three disabled clks
  task automatic tick(input int unsigned n);
    repeat (n) begin
      clk_enable = 1'b1;
      clocks(1);
      clk_enable = 1'b0;
      clocks(3);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h12;
    mem[16'h0302] = 8'h13; mem[16'h0303] = 8'h14;
    mem[16'h0304] = 8'h15; mem[16'h0305] = 8'h16;
    mem[16'h0306] = 8'h17; mem[16'h0307] = 8'h18;
    mem[16'h0308] = 8'h5A;
    mem[16'hFFFF] = 8'hA5;
    mem[16'h1234] = 8'h77;
    mem[16'h2000] = 8'h3C;

    reset = 1'b0; clk_enable = 1'b0; dmao = 1'b0; int_pixie = 1'b0;
    ie = 1'b0; r0_wr = 1'b0; r0_din = 16'h0000;
    clocks(3);
    reset = 1'b1;

    // ---- Reset state --------------------------------------------------------
    check("rst_sc",     32'(sc), 32'h0);
    check("rst_r0",     32'(r0), 32'h0);
    check("rst_data",   32'(data), 32'h0);
    check("rst_dcnt",   32'(dma_count), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_ack",    32'(int_ack), 32'h0);

    // ---- Idle alternation S0/S1 --------------------------------------------
    clk_enable = 1'b1;
    clocks(7);
    check("idle_s0_t7", 32'(sc), 32'h0);
    clocks(1);
    check("idle_s1", 32'(sc), 32'h1);
    clocks(8);
    check("idle_s0b", 32'(sc), 32'h0);
    check("idle_rd_none", rd_pulses, 0);
    check("idle_data", 32'(data), 32'h0);
    check("idle_r0", 32'(r0), 32'h0);

    // ---- Eight back-to-back DMA cycles from 0x0300 -------------------------
    r0_wr = 1'b1; r0_din = 16'h0300;
    clocks(1);
    r0_wr = 1'b0;
    check("r0_load", 32'(r0), 32'h0300);
    dmao = 1'b1;
    clocks(7);
    check("dma_pre_s1", 32'(sc), 32'h1);
    clocks(8);
    for (int k = 0; k < 8; k++) begin
      check("dma_sc",     32'(sc), 32'h2);
      check("dma_rd",     32'(mem_rd), 32'h1);
      check("dma_addr",   32'(mem_addr), 32'h0300 + 32'(k));
      clocks(1);
      check("dma_rd_off", 32'(mem_rd), 32'h0);
      clocks(1);
      check("dma_data",   32'(data), 32'h11 + 32'(k));
      clocks(5);
      if (k == 7) dmao = 1'b0;
      clocks(1);
    end
    check("dma_end_sc",   32'(sc), 32'h0);
    check("dma_end_r0",   32'(r0), 32'h0308);
    check("dma_end_cnt",  32'(dma_count), 32'h8);
    check("dma_end_data", 32'(data), 32'h18);
    check("dma_rd_count", rd_pulses, 8);
    clocks(8);
    check("post_dma_s1", 32'(sc), 32'h1);

    // ---- Interrupt with ie=1 -----------------------------------------------
    int_pixie = 1'b1; ie = 1'b1;
    clocks(8);
    check("int_sc",  32'(sc), 32'h3);
    check("int_ack", 32'(int_ack), 32'h1);
    int_pixie = 1'b0;
    clocks(1);
    check("int_ack_off", 32'(int_ack), 32'h0);
    check("int_cnt_clr", 32'(dma_count), 32'h0);
    check("int_sc_hold", 32'(sc), 32'h3);
    clocks(7);
    check("int_exit_s0", 32'(sc), 32'h0);

    // ---- Interrupt with ie=0: no S3 ----------------------------------------
    ie = 1'b0;
    clocks(8);
    check("noie_s1", 32'(sc), 32'h1);
    int_pixie = 1'b1;
    clocks(8);
    check("noie_s0", 32'(sc), 32'h0);
    int_pixie = 1'b0;
    clocks(8);
    check("noie_ack_count", ack_pulses, 1);

    // ---- DMA and interrupt together: DMA first, interrupt later ------------
    dmao = 1'b1; int_pixie = 1'b1; ie = 1'b1;
    clocks(8);
    check("both_s2", 32'(sc), 32'h2);
    dmao = 1'b0;
    clocks(2);
    check("both_data", 32'(data), 32'h5A);
    clocks(6);
    check("both_s0",  32'(sc), 32'h0);
    check("both_r0",  32'(r0), 32'h0309);
    check("both_cnt", 32'(dma_count), 32'h1);
    clocks(8);
    check("both_s1", 32'(sc), 32'h1);
    clocks(8);
    check("both_s3", 32'(sc), 32'h3);
    check("both_ack", 32'(int_ack), 32'h1);
    int_pixie = 1'b0;
    clocks(1);
    check("both_cnt_clr", 32'(dma_count), 32'h0);
    clocks(7);
    ie = 1'b0;
    check("both_exit_s0", 32'(sc), 32'h0);
    check("both_ack_count", ack_pulses, 2);

    // ---- R0 wrap at 0xFFFF --------------------------------------------------
    r0_wr = 1'b1; r0_din = 16'hFFFF;
    clocks(1);
    r0_wr = 1'b0; dmao = 1'b1;
    clocks(7);
    clocks(8);
    check("wrap_sc",   32'(sc), 32'h2);
    check("wrap_addr", 32'(mem_addr), 32'hFFFF);
    check("wrap_rd",   32'(mem_rd), 32'h1);
    dmao = 1'b0;
    clocks(2);
    check("wrap_data", 32'(data), 32'hA5);
    clocks(6);
    check("wrap_r0", 32'(r0), 32'h0000);

    // ---- R0 load beats the end-of-DMA increment -----------------------------
    r0_wr = 1'b1; r0_din = 16'h1234;
    clocks(1);
    r0_wr = 1'b0; dmao = 1'b1;
    clocks(7);
    clocks(8);
    check("ld_sc",   32'(sc), 32'h2);
    check("ld_addr", 32'(mem_addr), 32'h1234);
    dmao = 1'b0;
    clocks(7);
    r0_wr = 1'b1; r0_din = 16'h2000;
    clocks(1);
    r0_wr = 1'b0;
    check("ld_r0",  32'(r0), 32'h2000);
    check("ld_sc0", 32'(sc), 32'h0);
    check("ld_cnt", 32'(dma_count), 32'h2);

    // ---- Slow clk_enable (1 in 4) -------------------------------------------
    tick(7);
    clk_enable = 1'b1;
    clocks(1);
    check("slow_s1", 32'(sc), 32'h1);
    clk_enable = 1'b0;
    clocks(3);
    check("slow_s1_hold", 32'(sc), 32'h1);
    dmao = 1'b1;
    tick(8);
    dmao = 1'b0;
    check("slow_s2", 32'(sc), 32'h2);
    check("slow_rd_gated", 32'(mem_rd), 32'h0);
    clk_enable = 1'b1;
    #1;
    check("slow_rd_on", 32'(mem_rd), 32'h1);
    check("slow_addr",  32'(mem_addr), 32'h2000);
    clocks(1);
    clk_enable = 1'b0;
    #1;
    check("slow_rd_off", 32'(mem_rd), 32'h0);
    clocks(3);
    check("slow_data",     32'(data), 32'h3C);
    check("slow_rd_count", rd_pulses, 12);

    // ---- Reset in the middle of a DMA cycle (tick 5) ------------------------
    tick(4);
    check("mid_sc", 32'(sc), 32'h2);
    reset = 1'b0;
    clocks(1);
    reset = 1'b1;
    check("mrst_sc",   32'(sc), 32'h0);
    check("mrst_r0",   32'(r0), 32'h0);
    check("mrst_data", 32'(data), 32'h0);
    check("mrst_cnt",  32'(dma_count), 32'h0);
    clk_enable = 1'b1;
    clocks(7);
    check("mrst_s0_t7", 32'(sc), 32'h0);
    clocks(1);
    check("mrst_s1", 32'(sc), 32'h1);
    check("mrst_r0_noinc", 32'(r0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixie_dma_responder.md
Name: pixie_dma_responder

Overview:
- CPU-side bus-cycle sequencer that serves the Pixie display controller's DMA-out and interrupt requests, emulating CDP1802 timing.
- Generates the machine-cycle state code `sc` (fetch/execute/DMA/interrupt) that the Pixie front end uses for frame timing.
- Answers `dmao` by reading memory at R0, driving the byte on `data` during S2, then incrementing R0.
- Answers `int_pixie` with an S3 cycle and an `int_ack` pulse. Used as a stand-alone CPU model for Pixie bring-up and as the DMA engine in the core.

Parameters:
- CYCLE_TICKS, 8, `clk_enable` ticks per machine cycle (≥4).
- ADDR_W, 16, width of R0 and `mem_addr`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (`reset`=0 resets).
- clk_enable  in  1  CPU clock-enable tick; state advances only when high.
- dmao  in  1  DMA-out request from Pixie.
- int_pixie  in  1  interrupt request from Pixie.
- ie  in  1  CPU interrupt-enable flag.
- r0_wr  in  1  load R0 from `r0_din` (software DMA pointer set).
- r0_din  in  ADDR_W  new R0 value.
- sc  out  2  state code: 00 S0 fetch, 01 S1 execute, 10 S2 DMA, 11 S3 interrupt.
- mem_addr  out  ADDR_W  memory read address (= R0).
- mem_rd  out  1  one-clk memory read strobe.
- mem_rdata  in  8  memory read data, valid the clk after `mem_rd`.
- data  out  8  DMA byte presented to Pixie.
- int_ack  out  1  one-clk pulse at S3 start.
- r0  out  ADDR_W  current DMA pointer.
- dma_count  out  10  S2 cycles since last S3 entry.

Behaviour:
- Reset (`reset`=0 at a clk edge) clears all state: sc=00, tick counter t=0, r0=0, data=0, mem_rd=0, int_ack=0, dma_count=0. Reset takes priority over every other input, including mid-S2 (the pending R0 increment is discarded).
- Tick counter: t advances 0..CYCLE_TICKS-1 on each clk with `clk_enable`=1, then wraps to 0. With `clk_enable`=0 nothing changes except an `r0_wr` load.
- End of cycle is the tick with t=CYCLE_TICKS-1 and `clk_enable`=1. At that tick `sc` updates with this priority:
  - From S1, S2 or S3: if `dmao`=1, next state is S2.
  - From S1: else if `int_pixie`=1 and `ie`=1, next state is S3.
  - From S0: always S1. `dmao` and `int_pixie` are ignored in S0.
  - Otherwise: S0.
- Back-to-back S2 cycles continue while `dmao` stays high. Simultaneous `dmao` and interrupt at S1 end: S2 wins; the interrupt is taken only at a later S1 end (the requests are level-sampled, not latched).
- S2 read:
  - Clk with t=0 and `clk_enable`=1 in S2: `mem_rd`=1 for exactly that clk, `mem_addr`=r0.
  - Next clk (regardless of `clk_enable`): `data` <= `mem_rdata`.
  - `data` holds until the next S2 read; it is valid from S2 tick 1 through the end of the cycle.
  - At S2 end of cycle: r0 <= r0+1, wrapping 2^ADDR_W-1 to 0; `dma_count` <= `dma_count`+1, wrapping 1023 to 0.
- S3 entry:
  - Clk with t=0 and `clk_enable`=1: `int_ack`=1 for one clk; `dma_count` <= 0.
  - `ie` itself is owned externally.
- `mem_addr` = r0 at all times. `mem_rd`=0 outside S2 tick 0.
- `r0_wr`=1 loads `r0_din` on any clk, even with `clk_enable`=0. If it coincides with the S2 increment, the load wins and no increment occurs. A load during S2 before tick 0 changes the address read.
- Reads issue only from S2; `sc` changes only at end-of-cycle ticks.

Test Plan:
- Reset, then `clk_enable`=1 constantly with no requests -> `sc` alternates 00,01 every 8 clk; `mem_rd` never 1; `data`=00; r0=0000.
- r0_wr with 0x0300, memory[0x0300..0x0307]=0x11..0x18, `dmao` high for the duration of 8 S2 cycles -> eight consecutive sc=10 cycles; `data` 0x11..0x18 from tick 1 of each; r0=0x0308; `dma_count`=8; then back to the 00/01 alternation.
- `int_pixie`=1, `ie`=1 at S1 end -> sc=11 for 8 ticks; `int_ack` one clk at its tick 0; `dma_count` cleared to 0. Same stimulus with `ie`=0 -> no S3.
- `dmao`=1 and `int_pixie`=1 together at S1 end -> S2 first. `int_pixie` held, `dmao` dropped -> after S2 comes S0, S1, then S3.
- r0=0xFFFF, one S2 -> reads 0xFFFF, then r0=0x0000. In a separate S2 with r0=0x1234, `r0_wr` with 0x2000 on the end-of-cycle tick -> r0=0x2000, not 0x1235.
- `clk_enable` pulsed 1-in-4 -> every transition is stretched 4×, `mem_rd` still exactly 1 clk. `reset`=0 asserted at S2 tick 5 -> next clk sc=00, r0=0, `data`=0, no increment.
